ex_mdu: RTL

Iterative multiply/divide unit for the execute stage, parametrised in operand width. Accepts signed/unsigned MULT and DIV operations from decode and computes a 2×DATA_W result over multiple cycles (quotient in lo, remainder/upper product in hi). While an operation is in flight it requests a pipeline stall. Results are held for the HI/LO write path.

---
 rtl/ex_mdu_if.sv | 22 ++
 rtl/ex_mdu.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ex_mdu_if.sv
// ex_mdu_if: decode/HI-LO side handshake and result bus of the multiply/divide unit
interface ex_mdu_if #(parameter int DATA_W = 32);
    logic              start_i;
    logic [1:0]        op_i;
    logic [DATA_W-1:0] opa_i;
    logic [DATA_W-1:0] opb_i;
    logic              annul_i;
    logic              stallreq_o;
    logic              busy_o;
    logic              ready_o;
    logic              dz_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;
    modport master (
        output start_i, op_i, opa_i, opb_i, annul_i,
        input  stallreq_o, busy_o, ready_o, dz_o, hi_o, lo_o
    );
    modport slave (
        input  start_i, op_i, opa_i, opb_i, annul_i,
        output stallreq_o, busy_o, ready_o, dz_o, hi_o, lo_o
    );
endinterface

// File: rtl/ex_mdu.sv
// ex_mdu: iterative signed/unsigned multiply/divide unit; divider datapath present only when MDU_DIV_EN is defined
module ex_mdu #(
    parameter int DATA_W = 32
) (
    input logic    clk,
    input logic    rst,
    ex_mdu_if.slave mdu
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   m_q, m_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic                neg_lo_q, neg_lo_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                dz_q, dz_d;
    logic [DATA_W-1:0]   sav_hi_q, sav_hi_d, sav_lo_q, sav_lo_d;
    logic                sav_dz_q, sav_dz_d;

    logic                op_signed, sa, sb, last;
    logic [DATA_W-1:0]   abs_a, abs_b;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next, mul_res;

    assign op_signed = ~mdu.op_i[0];
    assign sa        = op_signed & mdu.opa_i[DATA_W-1];
    assign sb        = op_signed & mdu.opb_i[DATA_W-1];
    assign abs_a     = sa ? -mdu.opa_i : mdu.opa_i;
    assign abs_b     = sb ? -mdu.opb_i : mdu.opb_i;
    assign last      = cnt_q == CW'(DATA_W - 1);

    // Shift-add: low half holds the remaining multiplier bits, high half the partial sum
    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, {DATA_W{acc_q[0]}} & m_q};
    assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};
    assign mul_res  = neg_lo_q ? -mul_next : mul_next;

`ifdef MDU_DIV_EN
    logic                neg_hi_q, neg_hi_d;
    logic [DATA_W:0]     div_sh, div_diff;
    logic [2*DATA_W-1:0] div_next;
    logic [DATA_W-1:0]   quo_res, rem_res;
    // Restoring step: high half is the partial remainder, low half shifts dividend out and quotient in
    assign div_sh   = acc_q[2*DATA_W-1:DATA_W-1];
    assign div_diff = div_sh - {1'b0, m_q};
    assign div_next = div_diff[DATA_W] ? {div_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                       : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    assign quo_res  = neg_lo_q ? -div_next[DATA_W-1:0] : div_next[DATA_W-1:0];
    assign rem_res  = neg_hi_q ? -div_next[2*DATA_W-1:DATA_W] : div_next[2*DATA_W-1:DATA_W];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        acc_d    = acc_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;
`ifdef MDU_DIV_EN
        neg_hi_d = neg_hi_q;
`endif
        sav_hi_d = state_q == S_DONE ? sav_hi_q : hi_q;
        sav_lo_d = state_q == S_DONE ? sav_lo_q : lo_q;
        sav_dz_d = state_q == S_DONE ? sav_dz_q : dz_q;
        case (state_q)
            S_IDLE: if (mdu.start_i && !mdu.annul_i) begin
                cnt_d    = '0;
                neg_lo_d = sa ^ sb;
                if (!mdu.op_i[1]) begin
                    state_d = S_MUL;
                    m_d     = abs_a;
                    acc_d   = {{DATA_W{1'b0}}, abs_b};
                end else begin
`ifdef MDU_DIV_EN
                    neg_hi_d = sa;
                    m_d      = abs_b;
                    acc_d    = {{DATA_W{1'b0}}, abs_a};
                    state_d  = mdu.opb_i == '0 ? S_DONE : S_DIV;
                    if (mdu.opb_i == '0) begin
                        hi_d = mdu.opa_i;
                        lo_d = '1;
                        dz_d = 1'b1;
                    end
`else
                    state_d = S_DONE;
                    hi_d    = '0;
                    lo_d    = '0;
                    dz_d    = 1'b0;
`endif
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d      = S_DONE;
                    {hi_d, lo_d} = mul_res;
                    dz_d         = 1'b0;
                end
            end
`ifdef MDU_DIV_EN
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = S_DONE;
                    hi_d    = rem_res;
                    lo_d    = quo_res;
                    dz_d    = 1'b0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // A flush drops the operation; results revert to what was visible before it
        if (mdu.annul_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            hi_d    = state_q == S_DONE ? sav_hi_q : hi_q;
            lo_d    = state_q == S_DONE ? sav_lo_q : lo_q;
            dz_d    = state_q == S_DONE ? sav_dz_q : dz_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            neg_lo_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dz_q     <= 1'b0;
            sav_hi_q <= '0;
            sav_lo_q <= '0;
            sav_dz_q <= 1'b0;
`ifdef MDU_DIV_EN
            neg_hi_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            neg_lo_q <= neg_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dz_q     <= dz_d;
            sav_hi_q <= sav_hi_d;
            sav_lo_q <= sav_lo_d;
            sav_dz_q <= sav_dz_d;
`ifdef MDU_DIV_EN
            neg_hi_q <= neg_hi_d;
`endif
        end
    end

    assign mdu.stallreq_o = (state_q == S_IDLE && mdu.start_i && !mdu.annul_i)
                          || state_q == S_MUL || state_q == S_DIV;
    assign mdu.busy_o     = state_q != S_IDLE;
    assign mdu.ready_o    = state_q == S_DONE && !mdu.annul_i;
    assign mdu.dz_o       = dz_q;
    assign mdu.hi_o       = hi_q;
    assign mdu.lo_o       = lo_q;
endmodule
